md5_round_seq: RTL and testbench
================================

MD5_ROUND_SEQ -- requirements
Module: md5_round_seq

Interface
REQ-001 SHALL have parameter N_THREADS, default 4: number of interleaved thread slots; fixed at 4 in this revision.
REQ-002 SHALL have parameter N_CYCLES, default 72: Kt address range, made of 4 pad, 64 round and 4 pad entries.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: global advance; when 0, all state SHALL freeze.
REQ-006 SHALL have port start, input, 4 bits: per-slot run request, level-sensitive.
REQ-007 SHALL have port abort, input, 4 bits: per-slot cancel.
REQ-008 SHALL have port start_ack, output, 4 bits: one-cycle pulse marking that a slot's start was accepted.
REQ-009 SHALL have port busy, output, 4 bits: the slot is in state RUN.
REQ-010 SHALL have port done, output, 4 bits: one-cycle pulse when a slot issues t=71.
REQ-011 SHALL have port t, output, 7 bits: Kt address (round-constant table address).
REQ-012 SHALL have port Kt_en, output, 1 bit: t and the per-round fields are valid this cycle.
REQ-013 SHALL have port thread, output, 2 bits: slot that owns the current issue.
REQ-014 SHALL have port func, output, 2 bits: round function select, 0=F, 1=G, 2=H, 3=I.
REQ-015 SHALL have port msg_idx, output, 4 bits: message word index g.
REQ-016 SHALL have port shift, output, 5 bits: rotate amount.
REQ-017 SHALL have port pad, output, 1 bit: the current t is a pad entry (t<4 or t>67).

Function
REQ-018 SHALL keep a slot pointer ptr (2 bits) that increments mod 4 on every edge with en=1; it examines slot s=ptr only.
REQ-019 SHALL keep, per slot, a state in {IDLE, RUN} and a 7-bit counter cnt.
REQ-020 SHALL, at an edge with en=1 and slot s in IDLE with start[s]=1: register t=0 and Kt_en=1, pulse start_ack[s], set cnt[s]=1 and state RUN.
REQ-021 SHALL, at an edge with en=1 and slot s in RUN: register t=cnt[s] and Kt_en=1, then increment cnt[s].
REQ-022 SHALL, when slot s issues cnt[s]=71: pulse done[s] on the same registered cycle and set state IDLE; no new start for s is accepted before ptr next returns to s.
REQ-023 SHALL register Kt_en=0 at an edge where the examined slot is IDLE without start; t and the per-round fields then hold their previous values.
REQ-024 SHALL register all outputs; t, thread and the per-round fields SHALL appear together, one cycle after the edge that examined the slot.
REQ-025 SHALL, for 4<=t<=67 with r=t-4, set func=r[5:4].
REQ-026 SHALL set msg_idx by round group: group 0 r mod 16; group 1 (5r+1) mod 16; group 2 (3r+5) mod 16; group 3 7r mod 16.
REQ-027 SHALL set shift from r[1:0] per group: group 0 {7,12,17,22}; group 1 {5,9,14,20}; group 2 {4,11,16,23}; group 3 {6,10,15,21}.
REQ-028 SHALL, for pad entries, set func=0, msg_idx=0, shift=0 and pad=1; otherwise pad=0.
REQ-029 SHALL apply abort[s]=1 at any edge, regardless of en or ptr, by setting slot s to IDLE and cnt[s]=0, with no done[s] pulse.
REQ-030 SHALL give abort priority over both issue and start for slot s when both occur at the same edge; that edge SHALL then produce Kt_en=0 and no start_ack.
REQ-031 SHALL, with en=0, hold ptr and every cnt and state, register Kt_en=0, start_ack=0 and done=0, and still honour abort.
REQ-032 SHALL drive busy[s] combinationally from state RUN.
REQ-033 SHALL never issue two slots in one cycle; each running slot issues exactly one t per 4 enabled cycles.

Reset
REQ-034 SHALL, on rst_n=0, immediately set ptr=0, all slots IDLE with cnt=0, and all outputs to 0 (t, thread, func, msg_idx, shift, Kt_en, pad, start_ack, done, busy).
REQ-035 SHALL discard any in-flight run when reset is asserted mid-operation; no done pulse follows.
REQ-036 SHALL evaluate slot 0 first at the first enabled edge after reset is released.

Verification
REQ-037 Single slot: start=4'b0001 held, en=1 -> start_ack[0] at cycle 1; Kt_en every 4th cycle with t=0,1,...,71 in order; done[0] together with t=71; at t=4: func=0, msg_idx=0, shift=7, pad=0; at t=20: func=1, msg_idx=1, shift=5.
REQ-038 All four slots: start=4'b1111 -> thread cycles 0,1,2,3; every slot issues t=k at consecutive cycles 4k+1..4k+4; done pulses appear on 4 consecutive cycles.
REQ-039 Table check: t=36 gives func=2, msg_idx=5, shift=4; t=67 gives func=3, msg_idx=9, shift=21; t=68 gives pad=1 and func, msg_idx, shift all 0.
REQ-040 Abort: abort[1] at the edge where slot 1 would issue t=30 -> Kt_en=0 that cycle, busy[1]=0, no done[1], other slots unaffected.
REQ-041 Stall: en=0 for 10 cycles mid-run -> Kt_en=0 and t sequence resumes with no gap or repeat.
REQ-042 Reset: rst_n=0 while slot 2 is at t=50 -> all outputs 0 immediately; after release with start=0, Kt_en stays 0.

Source files
------------

// File: rtl/md5_round_seq.sv
// MD5 round sequencer: four interleaved thread slots share one issue port, one
// slot examined per enabled cycle; emits Kt address plus per-round F/G/H/I, g, s.
module md5_round_seq #(
  parameter int N_THREADS = 4,
  parameter int N_CYCLES  = 72
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_THREADS-1:0] start,
  input  logic [N_THREADS-1:0] abort,
  output logic [N_THREADS-1:0] start_ack,
  output logic [N_THREADS-1:0] busy,
  output logic [N_THREADS-1:0] done,
  output logic [6:0]           t,
  output logic                 Kt_en,
  output logic [1:0]           thread,
  output logic [1:0]           func,
  output logic [3:0]           msg_idx,
  output logic [4:0]           shift,
  output logic                 pad
);

  typedef enum logic {IDLE, RUN} slot_state_e;

  localparam logic [6:0] LAST_T = 7'(N_CYCLES - 1);

  slot_state_e state [N_THREADS];
  logic [6:0]  cnt   [N_THREADS];
  logic [1:0]  ptr;

  logic       accept;
  logic       issue;
  logic [6:0] t_next;
  logic [5:0] r;
  logic [1:0] grp;
  logic       pad_next;
  logic [1:0] func_next;
  logic [3:0] msg_next;
  logic [4:0] shift_next;

  // Issue decision for the slot under the pointer; abort beats start and issue.
  always_comb begin
    accept = en && !abort[ptr] && (state[ptr] == IDLE) && start[ptr];
    issue  = en && !abort[ptr] && (accept || (state[ptr] == RUN));
    t_next = accept ? 7'd0 : cnt[ptr];
  end

  // Round-field decode; r wraps mod 64, which is exact across the 64 rounds.
  always_comb begin
    r          = t_next[5:0] - 6'd4;
    grp        = r[5:4];
    pad_next   = (t_next < 7'd4) || (t_next > 7'd67);
    func_next  = grp;
    msg_next   = 4'd0;
    shift_next = 5'd0;
    unique case (grp)
      2'd0: msg_next = r[3:0];
      2'd1: msg_next = r[3:0] * 4'd5 + 4'd1;
      2'd2: msg_next = r[3:0] * 4'd3 + 4'd5;
      2'd3: msg_next = r[3:0] * 4'd7;
    endcase
    unique case ({grp, r[1:0]})
      4'h0: shift_next = 5'd7;
      4'h1: shift_next = 5'd12;
      4'h2: shift_next = 5'd17;
      4'h3: shift_next = 5'd22;
      4'h4: shift_next = 5'd5;
      4'h5: shift_next = 5'd9;
      4'h6: shift_next = 5'd14;
      4'h7: shift_next = 5'd20;
      4'h8: shift_next = 5'd4;
      4'h9: shift_next = 5'd11;
      4'ha: shift_next = 5'd16;
      4'hb: shift_next = 5'd23;
      4'hc: shift_next = 5'd6;
      4'hd: shift_next = 5'd10;
      4'he: shift_next = 5'd15;
      4'hf: shift_next = 5'd21;
    endcase
    if (pad_next) begin
      func_next  = 2'd0;
      msg_next   = 4'd0;
      shift_next = 5'd0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      start_ack <= '0;
      done      <= '0;
      Kt_en     <= 1'b0;
      t         <= '0;
      thread    <= '0;
      func      <= '0;
      msg_idx   <= '0;
      shift     <= '0;
      pad       <= 1'b0;
      for (int i = 0; i < N_THREADS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      start_ack <= '0;
      done      <= '0;
      Kt_en     <= 1'b0;
      if (en) begin
        ptr <= ptr + 2'd1;
        if (issue) begin
          Kt_en   <= 1'b1;
          t       <= t_next;
          thread  <= ptr;
          func    <= func_next;
          msg_idx <= msg_next;
          shift   <= shift_next;
          pad     <= pad_next;
          if (accept) begin
            start_ack[ptr] <= 1'b1;
            state[ptr]     <= RUN;
            cnt[ptr]       <= 7'd1;
          end else if (cnt[ptr] == LAST_T) begin
            done[ptr]  <= 1'b1;
            state[ptr] <= IDLE;
            cnt[ptr]   <= '0;
          end else begin
            cnt[ptr] <= cnt[ptr] + 7'd1;
          end
        end
      end
      // Abort acts on every slot at every edge, overriding the issue above.
      for (int i = 0; i < N_THREADS; i++) begin
        if (abort[i]) begin
          state[i] <= IDLE;
          cnt[i]   <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_THREADS; i++) busy[i] = (state[i] == RUN);
  end

endmodule

// File: tb/tb_md5_round_seq.sv
// Bench for md5_round_seq: reference MD5 schedule model checked every cycle,
// plus directed scenarios with hand-computed literals.
module tb_md5_round_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] start;
  logic [3:0] abort;
  logic [3:0] start_ack;
  logic [3:0] busy;
  logic [3:0] done;
  logic [6:0] t;
  logic       Kt_en;
  logic [1:0] thread;
  logic [1:0] func;
  logic [3:0] msg_idx;
  logic [4:0] shift;
  logic       pad;

  int n_tests = 0;
  int n_fail  = 0;

  md5_round_seq #(.N_THREADS(4), .N_CYCLES(72)) dut (
    .CLK(clk), .rst_n(rst_n), .en(en), .start(start), .abort(abort),
    .start_ack(start_ack), .busy(busy), .done(done), .t(t), .Kt_en(Kt_en),
    .thread(thread), .func(func), .msg_idx(msg_idx), .shift(shift), .pad(pad)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: MD5 round schedule from the published algorithm tables
  int grp_s [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
  bit m_run  [4];
  int m_next [4];
  int m_ptr;
  int e_t, e_thread, e_kten, e_func, e_msg, e_shift, e_pad;
  logic [3:0] e_ack, e_done;

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_run[s]  = 1'b0;
      m_next[s] = 0;
    end
    m_ptr = 0;
    e_t = 0; e_thread = 0; e_kten = 0; e_func = 0; e_msg = 0; e_shift = 0; e_pad = 0;
    e_ack = '0; e_done = '0;
  endtask

  task automatic emit(input int tt, input int s);
    int i;
    e_t = tt; e_thread = s; e_kten = 1;
    if (tt < 4 || tt > 67) begin
      e_func = 0; e_msg = 0; e_shift = 0; e_pad = 1;
    end else begin
      i = tt - 4;
      e_func  = i / 16;
      e_shift = grp_s[i / 16][i % 4];
      e_pad   = 0;
      if (i < 16)      e_msg = i;
      else if (i < 32) e_msg = (5 * i + 1) % 16;
      else if (i < 48) e_msg = (3 * i + 5) % 16;
      else             e_msg = (7 * i) % 16;
    end
  endtask

  task automatic model_step();
    int s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_ack = '0; e_done = '0; e_kten = 0;
    if (en) begin
      s = m_ptr;
      if (!abort[s]) begin
        if (!m_run[s] && start[s]) begin
          emit(0, s);
          e_ack[s] = 1'b1;
          m_run[s] = 1'b1;
          m_next[s] = 1;
        end else if (m_run[s]) begin
          emit(m_next[s], s);
          if (m_next[s] == 71) begin
            e_done[s] = 1'b1;
            m_run[s] = 1'b0;
          end
          m_next[s]++;
        end
      end
      m_ptr = (m_ptr + 1) % 4;
    end
    for (int k = 0; k < 4; k++) if (abort[k]) begin
      m_run[k] = 1'b0;
      m_next[k] = 0;
    end
  endtask

  // scoreboard: one compare per output every cycle, plus literal pins
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("kt_en", Kt_en, e_kten);
      check("start_ack", start_ack, e_ack);
      check("done", done, e_done);
      check("busy", busy, {m_run[3], m_run[2], m_run[1], m_run[0]});
      check("t", t, e_t);
      check("thread", thread, e_thread);
      check("func", func, e_func);
      check("msg_idx", msg_idx, e_msg);
      check("shift", shift, e_shift);
      check("pad", pad, e_pad);
      if (Kt_en) begin
        case (t)
          7'd4:  begin check("lit4_func", func, 0); check("lit4_msg", msg_idx, 0); check("lit4_shift", shift, 7); check("lit4_pad", pad, 0); end
          7'd20: begin check("lit20_func", func, 1); check("lit20_msg", msg_idx, 1); check("lit20_shift", shift, 5); end
          7'd36: begin check("lit36_func", func, 2); check("lit36_msg", msg_idx, 5); check("lit36_shift", shift, 4); end
          7'd67: begin check("lit67_func", func, 3); check("lit67_msg", msg_idx, 9); check("lit67_shift", shift, 21); end
          7'd68: begin check("lit68_pad", pad, 1); check("lit68_fields", {func, msg_idx, shift}, 0); end
          default: ;
        endcase
      end
      if (done != 4'd0) check("done_with_t71", t, 71);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_t"}, t, 0);
    check({tag, "_ctl"}, {Kt_en, pad, start_ack, done, busy}, 0);
    check({tag, "_fields"}, {thread, func, msg_idx, shift}, 0);
  endtask

  initial begin
    logic [3:0] d;
    int n;
    rst_n = 1'b0; en = 1'b0; start = '0; abort = '0;
    #1;
    check_all_zero("reset_init");
    repeat (3) tick();

    // single slot: start held until accepted
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; start = 4'b0001;
    tick();
    check("s1_ack", start_ack, 4'b0001);
    check("s1_t0", {Kt_en, t}, {1'b1, 7'd0});
    start = '0;
    n = 0;
    while (done == 4'd0 && n < 400) begin tick(); n++; end
    check("s1_timeout", n < 400, 1);
    check("s1_done_slot", done, 4'b0001);
    check("s1_done_t", t, 71);
    repeat (6) tick();

    // all four slots: done pulses on four consecutive cycles
    start = 4'b1111;
    repeat (4) tick();
    start = '0;
    n = 0;
    while (done == 4'd0 && n < 400) begin tick(); n++; end
    check("s4_timeout", n < 400, 1);
    d = done;
    for (int k = 0; k < 3; k++) begin
      tick();
      d = {d[2:0], d[3]};
      check("s4_done_seq", done, d);
    end
    repeat (6) tick();

    // abort slot 1 at its t=30 edge, then stall, then reset mid-run
    start = 4'b1111;
    repeat (4) tick();
    start = '0;
    n = 0;
    while (!(Kt_en && thread == 2'd1 && t == 7'd29) && n < 200) begin tick(); n++; end
    check("ab_timeout", n < 200, 1);
    repeat (3) tick();
    abort = 4'b0010;
    tick();
    check("ab_kt_en", Kt_en, 0);
    check("ab_busy", busy, 4'b1101);
    abort = '0;
    repeat (5) tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_kt_en", Kt_en, 0);
    end
    en = 1'b1;
    n = 0;
    while (!(Kt_en && thread == 2'd2 && t == 7'd50) && n < 300) begin tick(); n++; end
    check("rst_timeout", n < 300, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("post_rst_idle", {Kt_en, done, busy}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
